core_stream_loader: RTL and testbench
=====================================

Name: core_stream_loader

Overview:
- Per-core consumer placed directly downstream of one lane of the input core scanner (one m_valid/m_ready/m_last/m_data slice).
- Packs stream beats into full rows and writes them into the core's programming array (weights/couplings).
- Checks frame length against NUM_ROWS*BEATS_PER_ROW beats and reports completion or framing error to the control logic.

Parameters:
- DATA_WIDTH, `DATA_WIDTH_IN_STREAM, stream beat width.
- BEATS_PER_ROW, 4, beats packed into one array row.
- NUM_ROWS, 64, rows per complete frame.
- ADDR_WIDTH, $clog2(NUM_ROWS), row address width (derived; not overridden).

Ports:
- clk  in  1  core clock.
- resetb  in  1  synchronous reset, active-high (1 = reset), sampled on rising clk.
- s_valid  in  1  beat valid from scanner lane.
- s_ready  out  1  beat accept.
- s_last  in  1  final beat of frame.
- s_data  in  DATA_WIDTH  beat payload.
- core_busy  in  1  core annealing; array must not be written.
- wr_en  out  1  array row write strobe.
- wr_addr  out  ADDR_WIDTH  row address.
- wr_data  out  DATA_WIDTH*BEATS_PER_ROW  row data; beat 0 in LSBs.
- load_done  out  1  one-cycle pulse, complete frame written.
- frame_err  out  1  one-cycle pulse, frame length error.
- loaded  out  1  sticky, array holds a complete frame.

Behaviour:
- Reset values: s_ready=0, wr_en=0, wr_addr=0, wr_data=0, load_done=0, frame_err=0, loaded=0. FSM=IDLE; beat_cnt=row_cnt=0.
- Accept = s_valid & s_ready.
- s_ready = !core_busy in IDLE/LOAD; s_ready=1 in DRAIN (discard regardless of core_busy).
- Packing: the accepted beat is stored at slice beat_cnt of the row buffer; beat_cnt increments and wraps at BEATS_PER_ROW-1.
- Write: the cycle after accepting beat BEATS_PER_ROW-1, wr_en=1 for one cycle with wr_addr=row_cnt and wr_data=packed row; row_cnt then increments. Latency from last beat of a row to wr_en is 1 cycle. Full throughput: one beat per cycle, no bubbles.
- FSM:
  - IDLE: first accept -> LOAD; the beat is processed; loaded cleared.
  - LOAD, final position (row_cnt=NUM_ROWS-1, beat_cnt=BEATS_PER_ROW-1) with s_last=1: final row written; load_done=1 in the same cycle as that wr_en; loaded=1; -> IDLE; counters cleared.
  - LOAD, s_last=1 before the final position (short frame): partial row dropped; no write for that beat; frame_err pulse next cycle; loaded stays 0; -> IDLE; counters cleared. Rows already written are not rolled back.
  - LOAD, final position with s_last=0 (long frame): final row still written; frame_err pulses with that wr_en; -> DRAIN.
  - DRAIN: discard beats; accepted s_last -> IDLE. No load_done.
- Single-beat frame (s_last on first beat) with NUM_ROWS*BEATS_PER_ROW>1: treated as a short frame.
- core_busy rising mid-frame: stall only; counters hold; a pending wr_en already scheduled still issues.
- Reset mid-frame: state and counters cleared, pending write cancelled. Beats following reset start a new frame.
- load_done and frame_err are never asserted together.

Optional Feature:
- Macro: CORE_LOADER_ERR_COUNT_EN.
- Defined: adds output err_count [7:0]. It increments on each frame_err pulse, saturates at 255, and is cleared by reset only.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package core_loader_pkg holds:
  - state enum {IDLE, LOAD, DRAIN};
  - localparam helpers for ROW_WIDTH=DATA_WIDTH*BEATS_PER_ROW;
  - err counter width.
- One natural sub-module: core_row_packer. It contains beat_cnt, the row buffer, and the registered wr_en/wr_data. It emits a row_complete strobe to the FSM.

Test Plan (DATA_WIDTH=8, BEATS_PER_ROW=2, NUM_ROWS=4 unless stated):
- Clean frame 0x01..0x08, s_last on 8th beat, no stalls: writes (0,0x0201), (1,0x0403), (2,0x0605), (3,0x0807), each 1 cycle after the row's 2nd beat. load_done coincides with the addr-3 write; loaded=1.
- Short frame, 5 beats, s_last on beat 5: writes to addr 0,1 only; no write for beat 5; frame_err one pulse; load_done never; loaded=0.
- Long frame, 10 beats, s_last on beat 10: 4 writes; frame_err with the addr-3 write. Beats 9-10 discarded in DRAIN. Next frame loads normally from addr 0.
- core_busy=1 for 3 cycles after beat 3 with s_valid held: s_ready=0 for those cycles; data unchanged; final writes identical to the clean case.
- resetb pulsed after beat 3: no further writes and all outputs 0. Following 8-beat frame writes addr 0..3 with load_done. With CORE_LOADER_ERR_COUNT_EN: 300 short frames -> err_count=255.

Source files
------------

// File: rtl/core_loader_pkg.sv
// Shared types and helpers for the core stream loader (state encoding,
// row/address width helpers, error counter width).
`ifndef DATA_WIDTH_IN_STREAM
`define DATA_WIDTH_IN_STREAM 8
`endif

package core_loader_pkg;

    // Loader states, kept as plain constants so legacy tools see simple vectors.
    typedef logic [1:0] loader_state_t;
    localparam loader_state_t IDLE  = 2'd0;
    localparam loader_state_t LOAD  = 2'd1;
    localparam loader_state_t DRAIN = 2'd2;

    // Framing error counter width and its saturation value.
    localparam int ERR_CNT_WIDTH = 8;
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_CNT_MAX = '1;

    // Width of one packed array row.
    function automatic int row_width(input int data_width, input int beats_per_row);
        return data_width * beats_per_row;
    endfunction

    // Row address width; never narrower than one bit.
    function automatic int addr_width(input int num_rows);
        return (num_rows > 1) ? $clog2(num_rows) : 1;
    endfunction

endpackage

// File: rtl/core_row_packer.sv
// Packs stream beats into array rows. Holds the beat counter, the row
// buffer and the registered write strobe/data. A dropped beat (short
// frame terminator) discards the partial row without writing.
module core_row_packer
    import core_loader_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int BEATS_PER_ROW  = 4,
    localparam int ROW_WIDTH     = row_width(DATA_WIDTH, BEATS_PER_ROW),
    localparam int BEAT_CNT_WIDTH = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1
)(
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  beat_valid,
    input  logic [DATA_WIDTH-1:0] beat_data,
    input  logic                  drop,
    output logic                  last_slot,
    output logic                  row_complete,
    output logic                  wr_en,
    output logic [ROW_WIDTH-1:0]  wr_data
);

    logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [ROW_WIDTH-1:0]      row_buf_q, row_buf_d;
    logic                      wr_en_q, wr_en_d;
    logic [ROW_WIDTH-1:0]      wr_data_q, wr_data_d;

    assign last_slot    = (beat_cnt_q == BEAT_CNT_WIDTH'(BEATS_PER_ROW - 1));
    assign row_complete = beat_valid && !drop && last_slot;
    assign wr_en        = wr_en_q;
    assign wr_data      = wr_data_q;

    // Store the beat in its slot; on the last slot launch the full row.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        row_buf_d  = row_buf_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        if (beat_valid) begin
            if (drop) begin
                beat_cnt_d = '0;
            end else begin
                row_buf_d[beat_cnt_q*DATA_WIDTH +: DATA_WIDTH] = beat_data;
                if (last_slot) begin
                    beat_cnt_d = '0;
                    wr_en_d    = 1'b1;
                    wr_data_d  = row_buf_d;
                end else begin
                    beat_cnt_d = beat_cnt_q + BEAT_CNT_WIDTH'(1);
                end
            end
        end
    end

    // Register packer state; reset cancels any pending write.
    always_ff @(posedge clk) begin
        if (resetb) begin
            beat_cnt_q <= '0;
            row_buf_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            row_buf_q  <= row_buf_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
        end
    end

endmodule

// File: rtl/core_stream_loader.sv
// Per-core stream loader: packs scanner beats into rows, writes them into
// the programming array and checks frame length.
// Optional: define CORE_LOADER_ERR_COUNT_EN to add a saturating err_count output.
module core_stream_loader
    import core_loader_pkg::*;
#(
    parameter int DATA_WIDTH    = `DATA_WIDTH_IN_STREAM,
    parameter int BEATS_PER_ROW = 4,
    parameter int NUM_ROWS      = 64,
    localparam int ADDR_WIDTH   = addr_width(NUM_ROWS)
)(
    input  logic                                clk,
    input  logic                                resetb,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic                                s_last,
    input  logic [DATA_WIDTH-1:0]               s_data,
    input  logic                                core_busy,
    output logic                                wr_en,
    output logic [ADDR_WIDTH-1:0]               wr_addr,
    output logic [DATA_WIDTH*BEATS_PER_ROW-1:0] wr_data,
    output logic                                load_done,
    output logic                                frame_err,
    output logic                                loaded
`ifdef CORE_LOADER_ERR_COUNT_EN
    ,
    output logic [ERR_CNT_WIDTH-1:0]            err_count
`endif
);

    loader_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] row_cnt_q, row_cnt_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  load_done_q, load_done_d;
    logic                  frame_err_q, frame_err_d;
    logic                  loaded_q, loaded_d;

    logic accept;
    logic load_beat;
    logic last_slot;
    logic row_complete;
    logic final_pos;
    logic drop;

    // DRAIN swallows beats even while the core anneals; reset holds off input.
    assign s_ready   = !resetb && ((state_q == DRAIN) || !core_busy);
    assign accept    = s_valid && s_ready;
    assign load_beat = accept && (state_q != DRAIN);
    assign final_pos = (row_cnt_q == ADDR_WIDTH'(NUM_ROWS - 1)) && last_slot;
    assign drop      = s_last && !final_pos;

    assign wr_addr   = wr_addr_q;
    assign load_done = load_done_q;
    assign frame_err = frame_err_q;
    assign loaded    = loaded_q;

    core_row_packer #(
        .DATA_WIDTH    (DATA_WIDTH),
        .BEATS_PER_ROW (BEATS_PER_ROW)
    ) u_packer (
        .clk          (clk),
        .resetb       (resetb),
        .beat_valid   (load_beat),
        .beat_data    (s_data),
        .drop         (drop),
        .last_slot    (last_slot),
        .row_complete (row_complete),
        .wr_en        (wr_en),
        .wr_data      (wr_data)
    );

    // Frame FSM: track rows, classify frame end as complete/short/long.
    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        wr_addr_d   = wr_addr_q;
        load_done_d = 1'b0;
        frame_err_d = 1'b0;
        loaded_d    = loaded_q;
        case (state_q)
            IDLE, LOAD: begin
                if (load_beat) begin
                    state_d = LOAD;
                    if (state_q == IDLE) begin
                        loaded_d = 1'b0;
                    end
                    if (drop) begin
                        frame_err_d = 1'b1;
                        row_cnt_d   = '0;
                        state_d     = IDLE;
                    end else if (row_complete) begin
                        wr_addr_d = row_cnt_q;
                        if (final_pos) begin
                            row_cnt_d = '0;
                            if (s_last) begin
                                load_done_d = 1'b1;
                                loaded_d    = 1'b1;
                                state_d     = IDLE;
                            end else begin
                                frame_err_d = 1'b1;
                                state_d     = DRAIN;
                            end
                        end else begin
                            row_cnt_d = row_cnt_q + ADDR_WIDTH'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (accept && s_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register FSM state and the status pulses.
    always_ff @(posedge clk) begin
        if (resetb) begin
            state_q     <= IDLE;
            row_cnt_q   <= '0;
            wr_addr_q   <= '0;
            load_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            loaded_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            wr_addr_q   <= wr_addr_d;
            load_done_q <= load_done_d;
            frame_err_q <= frame_err_d;
            loaded_q    <= loaded_d;
        end
    end

`ifdef CORE_LOADER_ERR_COUNT_EN
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

    assign err_count = err_count_q;

    // Count framing error pulses, saturating at the top value.
    always_comb begin
        err_count_d = err_count_q;
        if (frame_err_q && (err_count_q != ERR_CNT_MAX)) begin
            err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
        end
    end

    // Error counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (resetb) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_core_stream_loader.sv
// Self-checking bench for core_stream_loader (DATA_WIDTH=8, BEATS_PER_ROW=2,
// NUM_ROWS=4). Expected array writes and status pulses are queued when a
// beat is accepted and checked when the DUT produces them.
module tb_core_stream_loader;

    logic        clk;
    logic        resetb;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic [7:0]  s_data;
    logic        core_busy;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic        load_done;
    logic        frame_err;
    logic        loaded;
`ifdef CORE_LOADER_ERR_COUNT_EN
    logic [7:0]  err_count;
`endif

    core_stream_loader #(
        .DATA_WIDTH    (8),
        .BEATS_PER_ROW (2),
        .NUM_ROWS      (4)
    ) dut (
        .clk       (clk),
        .resetb    (resetb),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_last    (s_last),
        .s_data    (s_data),
        .core_busy (core_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .load_done (load_done),
        .frame_err (frame_err),
        .loaded    (loaded)
`ifdef CORE_LOADER_ERR_COUNT_EN
        ,
        .err_count (err_count)
`endif
    );

    typedef struct {
        logic        isWrite;
        logic [1:0]  addr;
        logic [15:0] data;
        logic        done;
        logic        err;
        int          cycle;
    } evt_t;

    evt_t        evq[$];
    evt_t        curEvt;
    int          checks = 0;
    int          fails = 0;
    int          negCnt = 0;

    // Reference model of the loader's frame handling
    logic        mDrain = 1'b0;
    int          mBeat = 0;
    int          mRow = 0;
    logic [15:0] mBuf = 16'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pushEvt(input logic w, input logic [1:0] a, input logic [15:0] d,
                           input logic dn, input logic er, input int cyc);
        evt_t e;
        e.isWrite = w;
        e.addr    = a;
        e.data    = d;
        e.done    = dn;
        e.err     = er;
        e.cycle   = cyc;
        evq.push_back(e);
    endtask

    task automatic modelAccept(input logic [7:0] d, input logic last, input int cyc);
        logic finalPos;
        if (mDrain) begin
            if (last) mDrain = 1'b0;
        end else begin
            if (mBeat == 0) mBuf[7:0] = d;
            else            mBuf[15:8] = d;
            finalPos = (mRow == 3) && (mBeat == 1);
            if (last && !finalPos) begin
                pushEvt(1'b0, 2'd0, 16'h0, 1'b0, 1'b1, cyc);
                mBeat = 0;
                mRow  = 0;
            end else if (mBeat == 1) begin
                pushEvt(1'b1, 2'(mRow), mBuf, finalPos && last, finalPos && !last, cyc);
                mBeat = 0;
                if (finalPos) begin
                    mRow   = 0;
                    mDrain = !last;
                end else begin
                    mRow++;
                end
            end else begin
                mBeat = 1;
            end
        end
    endtask

    // Drive one beat, optionally stalled by core_busy, and wait for acceptance.
    task automatic applyStimulus(input logic [7:0] d, input logic last, input int busy);
        int waitCnt;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        if (busy > 0) begin
            core_busy = 1'b1;
            for (int i = 0; i < busy; i++) begin
                #1;
                checkOutput("busy_s_ready", 32'(s_ready), 32'd0);
                @(negedge clk);
            end
            core_busy = 1'b0;
        end
        #1;
        waitCnt = 0;
        while (!s_ready && waitCnt < 20) begin
            @(negedge clk);
            #1;
            waitCnt++;
        end
        if (!s_ready) begin
            checkOutput("ready_timeout", 32'(s_ready), 32'd1);
        end else begin
            modelAccept(d, last, negCnt + 1);
            @(posedge clk);
        end
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        checkOutput({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        checkOutput({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        checkOutput({tag, "_load_done"}, 32'(load_done), 32'd0);
        checkOutput({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        checkOutput({tag, "_loaded"}, 32'(loaded), 32'd0);
        checkOutput({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    endtask

    // Scoreboard: every write/status pulse must match the next queued event.
    always @(negedge clk) begin
        negCnt = negCnt + 1;
        while (evq.size() > 0 && evq[0].cycle < negCnt) begin
            checkOutput("missed_event_cycle", 32'(negCnt), 32'(evq[0].cycle));
            curEvt = evq.pop_front();
        end
        if (wr_en || load_done || frame_err) begin
            if (evq.size() == 0 || evq[0].cycle != negCnt) begin
                checkOutput("unexpected_event", {29'd0, wr_en, load_done, frame_err}, 32'd0);
            end else begin
                curEvt = evq.pop_front();
                checkOutput("wr_en", 32'(wr_en), 32'(curEvt.isWrite));
                if (curEvt.isWrite) begin
                    checkOutput("wr_addr", 32'(wr_addr), 32'(curEvt.addr));
                    checkOutput("wr_data", 32'(wr_data), 32'(curEvt.data));
                end
                checkOutput("load_done", 32'(load_done), 32'(curEvt.done));
                checkOutput("frame_err", 32'(frame_err), 32'(curEvt.err));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        s_valid   = 1'b0;
        s_last    = 1'b0;
        s_data    = 8'h00;
        core_busy = 1'b0;
        resetb    = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        checkIdleOutputs("reset");
        @(negedge clk);
        resetb = 1'b0;
        #1;
        checkOutput("idle_s_ready", 32'(s_ready), 32'd1);

        // Clean 8-beat frame
        $display("[TB] clean frame");
        for (int i = 1; i <= 8; i++) applyStimulus(8'(i), i == 8, 0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("clean_queue_drained", 32'(evq.size()), 32'd0);
        checkOutput("clean_loaded", 32'(loaded), 32'd1);

        // Short frame: 5 beats
        $display("[TB] short frame");
        for (int i = 1; i <= 5; i++) applyStimulus(8'(8'h10 + i), i == 5, 0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("short_queue_drained", 32'(evq.size()), 32'd0);
        checkOutput("short_loaded", 32'(loaded), 32'd0);

        // Long frame: 10 beats, then a normal frame
        $display("[TB] long frame");
        for (int i = 1; i <= 10; i++) applyStimulus(8'(8'h40 + i), i == 10, 0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("long_queue_drained", 32'(evq.size()), 32'd0);
        checkOutput("long_loaded", 32'(loaded), 32'd0);
`ifdef CORE_LOADER_ERR_COUNT_EN
        checkOutput("err_count_two", 32'(err_count), 32'd2);
`endif
        for (int i = 1; i <= 8; i++) applyStimulus(8'(8'h20 + i), i == 8, 0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("after_long_queue_drained", 32'(evq.size()), 32'd0);
        checkOutput("after_long_loaded", 32'(loaded), 32'd1);

        // Stall with core_busy for 3 cycles after beat 3
        $display("[TB] busy stall");
        for (int i = 1; i <= 8; i++) applyStimulus(8'(i), i == 8, (i == 4) ? 3 : 0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("busy_queue_drained", 32'(evq.size()), 32'd0);
        checkOutput("busy_loaded", 32'(loaded), 32'd1);

        // Reset mid-frame after beat 3
        $display("[TB] reset mid-frame");
        for (int i = 1; i <= 3; i++) applyStimulus(8'(8'h30 + i), 1'b0, 0);
        @(negedge clk);
        resetb = 1'b1;
        mDrain = 1'b0;
        mBeat  = 0;
        mRow   = 0;
        @(negedge clk);
        #1;
        checkIdleOutputs("midreset");
`ifdef CORE_LOADER_ERR_COUNT_EN
        checkOutput("err_count_cleared", 32'(err_count), 32'd0);
`endif
        resetb = 1'b0;
        for (int i = 1; i <= 8; i++) applyStimulus(8'(8'h50 + i), i == 8, 0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("postreset_queue_drained", 32'(evq.size()), 32'd0);
        checkOutput("postreset_loaded", 32'(loaded), 32'd1);

        // 300 single-beat (short) frames back to back
        $display("[TB] single-beat frames");
        for (int i = 0; i < 300; i++) applyStimulus(8'(i), 1'b1, 0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("single_queue_drained", 32'(evq.size()), 32'd0);
        checkOutput("single_loaded", 32'(loaded), 32'd0);
`ifdef CORE_LOADER_ERR_COUNT_EN
        checkOutput("err_count_saturated", 32'(err_count), 32'd255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
